// File: rtl/fp_sqrt_iter_pkg.sv
// Shared types and constant builders for the iterative floating-point square root.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

    typedef enum logic [2:0] {ZERO, NAN, NEG, PINF, NORM} op_class_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Patterns are built 128 bits wide; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [127:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        return (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 32'd1));
    endfunction

    function automatic logic [127:0] pinf(input int unsigned exp_w, input int unsigned man_w);
        return ((128'd1 << exp_w) - 128'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_sqrt_iter_if.sv
// Operand/result handshake bundle for fp_sqrt_iter; slave is the unit, master the user.
interface fp_sqrt_iter_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] n;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         invalid;

    modport master (
        output in_valid, n, out_ready,
        input  in_ready, out_valid, res, invalid
    );

    modport slave (
        input  in_valid, n, out_ready,
        output in_ready, out_valid, res, invalid
    );

endinterface

// File: rtl/fp_sqrt_iter_isqrt_step.sv
// One restoring square-root digit: bring down two radicand bits, try root*4+1.
module isqrt_step #(
    parameter int unsigned RW = 25
) (
    input  logic [RW+1:0] rem,
    input  logic [RW-1:0] root,
    input  logic [1:0]    pair,
    output logic [RW+1:0] rem_next,
    output logic [RW-1:0] root_next,
    output logic          digit
);
    logic [RW+3:0] trial_rem;
    logic [RW+3:0] trial_sub;
    logic [RW+1:0] diff;

    always_comb begin
        trial_rem = {rem, pair};
        trial_sub = {2'b00, root, 2'b01};
        digit     = (trial_rem >= trial_sub);
        diff      = trial_rem[RW+1:0] - trial_sub[RW+1:0];
        rem_next  = digit ? diff : trial_rem[RW+1:0];
        root_next = {root[RW-2:0], digit};
    end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative RNE square root, one root bit per cycle, with a bypass for special operands.
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic          CLK,
    input  logic          RST,
    fp_sqrt_iter_if.slave bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned RW = MAN_W + 2;
    localparam int unsigned CW = $clog2(MAN_W + 3);

    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(bias(EXP_W));
    localparam logic [127:0]     QNAN_F = qnan(EXP_W, MAN_W);
    localparam logic [127:0]     PINF_F = pinf(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN   = QNAN_F[W-1:0];
    localparam logic [W-1:0]     PINF_V = PINF_F[W-1:0];
    localparam logic [CW-1:0]    LAST   = CW'(RW - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*RW-1:0] rad;
    logic [RW+1:0]   rem;
    logic [RW-1:0]   root;
    logic [EXP_W-1:0] exp_r;
    logic [W-1:0]    res_q;
    logic            inv_q;
    logic            valid_q;

    logic             sign;
    logic [EXP_W-1:0] e_fld;
    logic [MAN_W-1:0] m_fld;
    op_class_t        cls;
    logic [EXP_W:0]   e_sum;
    logic [EXP_W-1:0] exp_next;
    logic [2*RW-1:0]  rad_init;

    logic [RW+1:0]    rem_next;
    logic [RW-1:0]    root_next;
    logic             digit;

    logic             inc;
    logic [MAN_W:0]   rounded;
    logic             carry;

    assign sign  = bus.n[W-1];
    assign e_fld = bus.n[W-2:MAN_W];
    assign m_fld = bus.n[MAN_W-1:0];

    always_comb begin
        cls = NORM;
        if (e_fld == '0)
            cls = ZERO;
        else if (e_fld == '1)
            cls = (m_fld != '0) ? NAN : (sign ? NEG : PINF);
        else if (sign)
            cls = NEG;
    end

    // BIAS is odd, so floor((E-BIAS)/2)+BIAS == floor((E+BIAS)/2), and an odd
    // unbiased exponent shows up as the low bit of E+BIAS.
    always_comb begin
        e_sum    = {1'b0, e_fld} + {1'b0, BIAS_E};
        exp_next = e_sum[EXP_W:1];
        rad_init = e_sum[0] ? {1'b1, m_fld, 1'b0, {RW{1'b0}}}
                            : {2'b01, m_fld, {RW{1'b0}}};
    end

    isqrt_step #(.RW(RW)) u_step (
        .rem       (rem),
        .root      (root),
        .pair      (rad[2*RW-1:2*RW-2]),
        .rem_next  (rem_next),
        .root_next (root_next),
        .digit     (digit)
    );

    // Hidden bit enters as 1, so it reads 0 after rounding only when the mantissa carried out.
    always_comb begin
        inc     = root[0] & ((rem != '0) | root[1]);
        rounded = root[RW-1:1] + {{MAN_W{1'b0}}, inc};
        carry   = ~rounded[MAN_W];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            exp_r   <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cnt   <= '0;
                        inv_q <= 1'b0;
                        case (cls)
                            NORM: begin
                                rad   <= rad_init;
                                rem   <= '0;
                                root  <= '0;
                                exp_r <= exp_next;
                                state <= ITER;
                            end
                            ZERO: begin
                                res_q <= {sign, {(W-1){1'b0}}};
                                state <= DONE;
                            end
                            NAN: begin
                                res_q <= QNAN;
                                state <= DONE;
                            end
                            NEG: begin
                                res_q <= QNAN;
                                inv_q <= 1'b1;
                                state <= DONE;
                            end
                            PINF: begin
                                res_q <= PINF_V;
                                state <= DONE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                ITER: begin
                    rad  <= {rad[2*RW-3:0], 2'b00};
                    rem  <= rem_next;
                    root <= root_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST)
                        state <= ROUND;
                end
                ROUND: begin
                    res_q   <= {1'b0, exp_r + {{(EXP_W-1){1'b0}}, carry}, rounded[MAN_W-1:0]};
                    inv_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.res       = res_q;
    assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: float32 and half-precision instances against a scoreboard.
module tb_fp_sqrt_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_sqrt_iter_if #(.EXP_W(8), .MAN_W(23)) b32 ();
    fp_sqrt_iter_if #(.EXP_W(5), .MAN_W(10)) b16 ();

    fp_sqrt_iter #(.EXP_W(8), .MAN_W(23)) dut32 (.CLK(clk), .RST(rst_n), .bus(b32));
    fp_sqrt_iter #(.EXP_W(5), .MAN_W(10)) dut16 (.CLK(clk), .RST(rst_n), .bus(b16));

    typedef struct {
        logic [31:0] res;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] ref_half(input logic [15:0] x);
        real v, r, s, fr;
        int ue, ex, fl;
        logic [4:0] eb;
        logic [9:0] mb;
        v  = 1.0 + real'(x[9:0]) / 1024.0;
        ue = int'(x[14:10]) - 15;
        if (ue > 0) repeat (ue) v = v * 2.0;
        else        repeat (-ue) v = v / 2.0;
        r  = $sqrt(v);
        ex = 0;
        while (r >= 2.0) begin r = r / 2.0; ex++; end
        while (r < 1.0)  begin r = r * 2.0; ex--; end
        s  = r * 1024.0;
        fl = $rtoi(s);
        fr = s - real'(fl);
        if (fr > 0.5 || (fr == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 2048) begin fl = 1024; ex++; end
        eb = 5'(ex + 15);
        mb = 10'(fl - 1024);
        return {1'b0, eb, mb};
    endfunction

    task automatic send(input bit h, input logic [31:0] v, input logic [31:0] r,
                        input logic inv, output bit tmo);
        int unsigned g;
        exp_t t;
        g   = 0;
        tmo = 1'b0;
        @(negedge clk);
        while (!(h ? b16.in_ready : b32.in_ready) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            tmo = 1'b1;
            return;
        end
        t.res = r;
        t.inv = inv;
        sb.push_back(t);
        if (h) begin b16.in_valid = 1'b1; b16.n = v[15:0]; end
        else   begin b32.in_valid = 1'b1; b32.n = v; end
        @(posedge clk);
        @(negedge clk);
        b16.in_valid = 1'b0;
        b32.in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit h, output int lat, output bit tmo);
        lat = 0;
        tmo = 1'b0;
        while (!(h ? b16.out_valid : b32.out_valid)) begin
            if (lat >= 100) begin
                tmo = 1'b1;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        b32.in_valid = 1'b0; b32.n = '0; b32.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.n = '0; b16.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid32 got=%b want=0", b32.out_valid); end
        total++; if (b32.res !== 32'h0) begin bad++; $display("FAIL rst_res32 got=%h want=00000000", b32.res); end
        total++; if (b32.invalid !== 1'b0) begin bad++; $display("FAIL rst_inv32 got=%b want=0", b32.invalid); end
        total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid16 got=%b want=0", b16.out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready32 got=%b want=1", b32.in_ready); end
        total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready16 got=%b want=1", b16.in_ready); end
    endtask

    task automatic test_normal32();
        logic [31:0] ops [3] = '{32'h3F400000, 32'h40800000, 32'h40000000};
        logic [31:0] want[3] = '{32'h3F5DB3D7, 32'h40000000, 32'h3FB504F3};
        int lat;
        bit tmo;
        exp_t e;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, ops[i], want[i], 1'b0, tmo);
            if (tmo) begin total++; bad++; $display("FAIL norm32_accept[%0d] got=timeout want=accept", i); continue; end
            wait_out(1'b0, lat, tmo);
            e = sb.pop_front();
            if (tmo) begin total++; bad++; $display("FAIL norm32_wait[%0d] got=timeout want=out_valid", i); continue; end
            total++; if (lat !== 26) begin bad++; $display("FAIL norm32_lat[%0d] got=%0d want=26", i, lat); end
            total++; if (b32.res !== e.res) begin bad++; $display("FAIL norm32_res[%0d] got=%h want=%h", i, b32.res, e.res); end
            total++; if (b32.invalid !== e.inv) begin bad++; $display("FAIL norm32_inv[%0d] got=%b want=%b", i, b32.invalid, e.inv); end
        end
    endtask

    task automatic test_special();
        logic [31:0] ops [4] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h00000001};
        logic [31:0] want[4] = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000};
        logic        inv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        bit tmo;
        exp_t e;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, ops[i], want[i], inv[i], tmo);
            if (tmo) begin total++; bad++; $display("FAIL spec_accept[%0d] got=timeout want=accept", i); continue; end
            wait_out(1'b0, lat, tmo);
            e = sb.pop_front();
            if (tmo) begin total++; bad++; $display("FAIL spec_wait[%0d] got=timeout want=out_valid", i); continue; end
            total++; if (lat !== 1) begin bad++; $display("FAIL spec_lat[%0d] got=%0d want=1", i, lat); end
            total++; if (b32.res !== e.res) begin bad++; $display("FAIL spec_res[%0d] got=%h want=%h", i, b32.res, e.res); end
            total++; if (b32.invalid !== e.inv) begin bad++; $display("FAIL spec_inv[%0d] got=%b want=%b", i, b32.invalid, e.inv); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit tmo;
        exp_t e;
        b32.out_ready = 1'b0;
        send(1'b0, 32'h40800000, 32'h40000000, 1'b0, tmo);
        wait_out(1'b0, lat, tmo);
        e = sb.pop_front();
        if (tmo) begin total++; bad++; $display("FAIL bp_wait got=timeout want=out_valid"); return; end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 2) begin b32.in_valid = 1'b1; b32.n = 32'h3F800000; end
            if (i == 6) b32.in_valid = 1'b0;
            total++; if (b32.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, b32.out_valid); end
            total++; if (b32.res !== e.res) begin bad++; $display("FAIL bp_res[%0d] got=%h want=%h", i, b32.res, e.res); end
            total++; if (b32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, b32.in_ready); end
        end
        b32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b32.out_ready = 1'b0;
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle got=%b want=1", b32.in_ready); end
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", b32.out_valid); end
        b32.out_ready = 1'b1;
        send(1'b0, 32'h40000000, 32'h3FB504F3, 1'b0, tmo);
        if (tmo) begin total++; bad++; $display("FAIL bp_next_accept got=timeout want=accept"); return; end
        wait_out(1'b0, lat, tmo);
        e = sb.pop_front();
        if (tmo) begin total++; bad++; $display("FAIL bp_next_wait got=timeout want=out_valid"); return; end
        total++; if (b32.res !== e.res) begin bad++; $display("FAIL bp_next_res got=%h want=%h", b32.res, e.res); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit tmo;
        exp_t e;
        b32.out_ready = 1'b1;
        send(1'b0, 32'h40800000, 32'h40000000, 1'b0, tmo);
        if (!tmo) void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.res !== 32'h0) begin bad++; $display("FAIL rmid_res got=%h want=00000000", b32.res); end
        total++; if (b32.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", b32.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        b32.out_ready = 1'b0;
        send(1'b0, 32'hBF800000, 32'h7FC00000, 1'b1, tmo);
        wait_out(1'b0, lat, tmo);
        e = sb.pop_front();
        if (tmo) begin total++; bad++; $display("FAIL rdone_wait got=timeout want=out_valid"); end
        total++; if (b32.invalid !== e.inv) begin bad++; $display("FAIL rdone_inv_pre got=%b want=%b", b32.invalid, e.inv); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (b32.out_valid !== 1'b0) begin bad++; $display("FAIL rdone_valid got=%b want=0", b32.out_valid); end
        total++; if (b32.res !== 32'h0) begin bad++; $display("FAIL rdone_res got=%h want=00000000", b32.res); end
        total++; if (b32.invalid !== 1'b0) begin bad++; $display("FAIL rdone_inv got=%b want=0", b32.invalid); end
        @(negedge clk);
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        send(1'b0, 32'h40800000, 32'h40000000, 1'b0, tmo);
        if (tmo) begin total++; bad++; $display("FAIL rpost_accept got=timeout want=accept"); return; end
        wait_out(1'b0, lat, tmo);
        e = sb.pop_front();
        if (tmo) begin total++; bad++; $display("FAIL rpost_wait got=timeout want=out_valid"); return; end
        total++; if (b32.res !== e.res) begin bad++; $display("FAIL rpost_res got=%h want=%h", b32.res, e.res); end
        total++; if (lat !== 26) begin bad++; $display("FAIL rpost_lat got=%0d want=26", lat); end
    endtask

    task automatic test_half();
        int lat;
        bit tmo;
        exp_t e;
        logic [15:0] x;
        logic [4:0]  eb;
        logic [9:0]  mb;
        b16.out_ready = 1'b1;
        send(1'b1, 32'h00004400, 32'h00004000, 1'b0, tmo);
        wait_out(1'b1, lat, tmo);
        e = sb.pop_front();
        if (tmo) begin total++; bad++; $display("FAIL half4_wait got=timeout want=out_valid"); end
        total++; if (lat !== 13) begin bad++; $display("FAIL half4_lat got=%0d want=13", lat); end
        total++; if ({16'h0, b16.res} !== e.res) begin bad++; $display("FAIL half4_res got=%h want=%h", b16.res, e.res); end
        for (int i = 0; i < 2000; i++) begin
            eb = 5'($urandom_range(1, 30));
            mb = 10'($urandom_range(0, 1023));
            x  = {1'b0, eb, mb};
            send(1'b1, {16'h0, x}, {16'h0, ref_half(x)}, 1'b0, tmo);
            if (tmo) begin total++; bad++; $display("FAIL halfr_accept[%0d] got=timeout want=accept", i); continue; end
            wait_out(1'b1, lat, tmo);
            e = sb.pop_front();
            if (tmo) begin total++; bad++; $display("FAIL halfr_wait[%0d] got=timeout want=out_valid", i); continue; end
            total++;
            if ({16'h0, b16.res} !== e.res || b16.invalid !== e.inv) begin
                bad++;
                $display("FAIL halfr[%0d] n=%h got=%h/%b want=%h/%b", i, x, b16.res, b16.invalid, e.res[15:0], e.inv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal32();
        test_special();
        test_backpressure();
        test_reset_mid();
        test_half();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
